// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
// Segment codes are logical active-high, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [6:0] SEG_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] hex2seg(input logic [3:0] nibble);
        return SEG_HEX[nibble];
    endfunction

    // Width of the digit index; a single-digit bank still gets one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to logical seven-segment code.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] code
);

    always_comb begin
        code = hex2seg(nibble);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex display driver with frame-synchronous double buffering.
// Define SEG7_LZ_BLANK_EN to enable leading-zero suppression.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 100000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 load,
    input  logic [4*NUM_DIGITS-1:0]              value,
    input  logic [NUM_DIGITS-1:0]                blank_mask,
    output logic [6:0]                           seg,
    output logic [NUM_DIGITS-1:0]                an,
    output logic [idx_width(NUM_DIGITS)-1:0]     digit_idx,
    output logic                                 frame_pulse,
    output logic                                 pending
);

    localparam int IW = idx_width(NUM_DIGITS);
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [IW-1:0] LAST_DIGIT = IW'(NUM_DIGITS - 1);
    localparam logic [PW-1:0] LAST_TICK  = PW'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? ~SEG_BLANK : SEG_BLANK;
    localparam logic [NUM_DIGITS-1:0] AN_OFF =
        (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [PW-1:0]           prescaler;
    logic                    first_cycle;
    logic                    tick;
    logic                    frame_start;
    logic [4*NUM_DIGITS-1:0] shadow_value, active_value;
    logic [NUM_DIGITS-1:0]   shadow_mask, active_mask;
    logic [NUM_DIGITS-1:0]   dark_vec;
    logic [NUM_DIGITS-1:0]   onehot;
    logic [3:0]              cur_nibble;
    logic                    cur_dark;
    logic [6:0]              cur_code;
    logic [6:0]              seg_logic, seg_next;
    logic [NUM_DIGITS-1:0]   an_logic, an_next;

    // The cycle after reset release counts as a frame start.
    always_comb begin
        tick        = (prescaler == LAST_TICK);
        frame_start = first_cycle | (tick & (digit_idx == LAST_DIGIT));
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler   <= '0;
            digit_idx   <= '0;
            first_cycle <= 1'b1;
            frame_pulse <= 1'b0;
        end else begin
            first_cycle <= 1'b0;
            frame_pulse <= frame_start;
            if (tick) begin
                prescaler <= '0;
                digit_idx <= (digit_idx == LAST_DIGIT) ? '0 : digit_idx + 1'b1;
            end else begin
                prescaler <= prescaler + 1'b1;
            end
        end
    end

    // NOTE: the buffers are reset too, so a value captured before a reset is never shown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_value <= '0;
            shadow_mask  <= '0;
            active_value <= '0;
            active_mask  <= '0;
            pending      <= 1'b0;
        end else begin
            if (frame_start && pending) begin
                active_value <= shadow_value;
                active_mask  <= shadow_mask;
            end
            if (load) begin
                shadow_value <= value;
                shadow_mask  <= blank_mask;
                pending      <= 1'b1;
            end else if (frame_start) begin
                pending      <= 1'b0;
            end
        end
    end

`ifdef SEG7_LZ_BLANK_EN
    logic [NUM_DIGITS-1:0] lz_dark;

    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        logic upper_zero;
        lz_dark    = '0;
        upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            upper_zero = upper_zero & (active_value[4*i +: 4] == 4'h0);
            lz_dark[i] = upper_zero;
        end
    end

    assign dark_vec = active_mask | lz_dark;
`else
    assign dark_vec = active_mask;
`endif

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        cur_nibble = 4'h0;
        cur_dark   = 1'b0;
        onehot     = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (int'(digit_idx) == i) begin
                cur_nibble = active_value[4*i +: 4];
                cur_dark   = dark_vec[i];
                onehot[i]  = 1'b1;
            end
        end
    end

    seg7_hex_decode u_decode (
        .nibble (cur_nibble),
        .code   (cur_code)
    );

    // Prescaler at zero means the index just moved: hold the enables off for one cycle.
    always_comb begin
        seg_logic = cur_dark ? SEG_BLANK : cur_code;
        an_logic  = ((prescaler == '0) || cur_dark) ? '0 : onehot;
        seg_next  = (SEG_ACTIVE_LOW != 0) ? ~seg_logic : seg_logic;
        an_next   = (AN_ACTIVE_LOW != 0) ? ~an_logic : an_logic;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= SEG_OFF;
            an  <= AN_OFF;
        end else begin
            seg <= seg_next;
            an  <= an_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (NUM_DIGITS=4, REFRESH_DIV=4, low-true pins).
// Honours SEG7_LZ_BLANK_EN when the design is built with it.
module tb_seg7_scan_driver;

    localparam int ND    = 4;
    localparam int DIV   = 4;
    localparam int FRAME = ND * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  blank_mask;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [1:0]  digit_idx;
    logic        frame_pulse;
    logic        pending;

    seg7_scan_driver #(
        .NUM_DIGITS     (ND),
        .REFRESH_DIV    (DIV),
        .SEG_ACTIVE_LOW (1),
        .AN_ACTIVE_LOW  (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .value       (value),
        .blank_mask  (blank_mask),
        .seg         (seg),
        .an          (an),
        .digit_idx   (digit_idx),
        .frame_pulse (frame_pulse),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] an;
    } slot_t;

    int checks = 0;
    int errors = 0;
    int t = 0;
    slot_t exp_q[$];

    logic [6:0] hex_tab [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic [15:0] m_sh_v, m_act_v;
    logic [3:0]  m_sh_m, m_act_m;
    logic        m_pend;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
        end
    endtask

    function automatic logic digit_dark(input logic [15:0] v, input logic [3:0] m, input int i);
        logic dark;
        dark = m[i];
`ifdef SEG7_LZ_BLANK_EN
        if (i > 0 && (v >> (4 * i)) == 16'h0) dark = 1'b1;
`endif
        return dark;
    endfunction

    function automatic logic [6:0] pin_seg(input logic [15:0] v, input logic [3:0] m, input int i);
        return digit_dark(v, m, i) ? 7'h7F : ~hex_tab[v[4*i +: 4]];
    endfunction

    function automatic logic [3:0] pin_an(input logic [15:0] v, input logic [3:0] m, input int i);
        return digit_dark(v, m, i) ? 4'hF : ~(4'b0001 << i);
    endfunction

    // Monitor and reference model: checks the state after t edges, then steps the model.
    initial begin
        logic        fs;
        logic [15:0] n_act_v, n_sh_v;
        logic [3:0]  n_act_m, n_sh_m;
        logic        n_pend;
        slot_t       e;
        int          pre, idx;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_seg", seg, 7'h7F);
                check("rst_an", an, 4'hF);
                check("rst_pending", pending, 1'b0);
                check("rst_frame_pulse", frame_pulse, 1'b0);
                check("rst_digit_idx", digit_idx, 2'd0);
                m_sh_v = '0; m_sh_m = '0; m_act_v = '0; m_act_m = '0; m_pend = 1'b0;
                exp_q.delete();
                t = 0;
            end else begin
                if (t >= 1) begin
                    pre = t % DIV;
                    idx = (t / DIV) % ND;
                    check("frame_pulse", frame_pulse, (t == 1 || t % FRAME == 0));
                    check("digit_idx", digit_idx, idx);
                    check("pending", pending, m_pend);
                    if (pre == 1) begin
                        check("gap_an", an, 4'hF);
                        check("gap_seg", seg, pin_seg(m_act_v, m_act_m, idx));
                    end else if (pre == 2) begin
                        if (exp_q.size() == 0) begin
                            check("sb_underflow", exp_q.size(), 1);
                        end else begin
                            e = exp_q.pop_front();
                            check("slot_seg", seg, e.seg);
                            check("slot_an", an, e.an);
                        end
                    end
                end
                fs      = (t + 1 == 1) || ((t + 1) % FRAME == 0);
                n_act_v = (fs && m_pend) ? m_sh_v : m_act_v;
                n_act_m = (fs && m_pend) ? m_sh_m : m_act_m;
                n_sh_v  = load ? value : m_sh_v;
                n_sh_m  = load ? blank_mask : m_sh_m;
                n_pend  = load ? 1'b1 : (fs ? 1'b0 : m_pend);
                if (fs) begin
                    for (int i = 0; i < ND; i++) begin
                        e.seg = pin_seg(n_act_v, n_act_m, i);
                        e.an  = pin_an(n_act_v, n_act_m, i);
                        exp_q.push_back(e);
                    end
                end
                m_act_v = n_act_v; m_act_m = n_act_m;
                m_sh_v = n_sh_v; m_sh_m = n_sh_m; m_pend = n_pend;
                t++;
            end
        end
    end

    task automatic wait_state(input int k);
        do begin
            @(posedge clk);
            #1;
        end while (t % FRAME != k);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] m, input int k);
        wait_state(k);
        load       = 1'b1;
        value      = v;
        blank_mask = m;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    initial begin
        logic [3:0] nib;
        rst = 1'b1; load = 1'b0; value = '0; blank_mask = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        do_load(16'h1A2F, 4'b0000, 5);
        wait_state(14);
        for (int n = 0; n < 16; n++) begin
            nib = n[3:0];
            do_load({4{nib}}, 4'b0000, 8);
        end

        do_load(16'h0C3E, 4'b0000, 6);
        do_load(16'hB7D9, 4'b0000, 15);
        repeat (FRAME) @(posedge clk);
        #1;

        do_load(16'h1234, 4'b0101, 3);
        do_load(16'h0040, 4'b0000, 3);
        do_load(16'h0000, 4'b0000, 3);
        do_load(16'h8E60, 4'b1000, 3);

        do_load(16'h9999, 4'b0000, 5);
        wait_state(9);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2 * FRAME + 4) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout t=%0d", t);
        $fatal(1, "timeout");
    end

endmodule
